// File: rtl/chan_pkt_framer.sv
// Frames channelizer output into {header, payload, trailer} packets keyed by bin index.
// Optional build macro CHAN_FRAMER_TIMESTAMP_EN adds a cycle-count timestamp header word.
`timescale 1ns/1ps
module chan_pkt_framer #(
    parameter int          BIN_WIDTH = 11,
    parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
    input  logic        clk,
    input  logic        async_reset_n,
    input  logic [15:0] payload_length,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    input  logic [23:0] s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
`ifdef CHAN_FRAMER_TIMESTAMP_EN
        S_TS,
`endif
        S_PAYLOAD,
        S_TRAILER
    } state_t;

    state_t               state_q;
    logic [BIN_WIDTH-1:0] cur_bin_q;
    logic [15:0]          len_q;
    logic [15:0]          count_q;
    logic [2:0]           reason_q;
    logic [15:0]          seq_q;
    logic [15:0]          pkt_cnt_q;
    logic                 m_tvalid_q;
    logic [31:0]          m_tdata_q;
    logic                 m_tlast_q;

    logic [BIN_WIDTH-1:0] s_bin;
    logic                 out_free, bin_match, s_hs, trl_done;
    logic                 close_last, close_len;
    logic [15:0]          cnt_inc, seq_inc, hdr_seq;
    logic                 unused_tuser;

    assign s_bin        = s_axis_tuser[BIN_WIDTH-1:0];
    assign unused_tuser = ^s_axis_tuser[23:BIN_WIDTH];
    assign out_free     = !m_tvalid_q || m_axis_tready;
    assign bin_match    = (s_bin == cur_bin_q);
    assign s_axis_tready = (state_q == S_PAYLOAD) && out_free && bin_match;
    assign s_hs         = s_axis_tvalid && s_axis_tready;
    assign trl_done     = m_tvalid_q && m_axis_tready && m_tlast_q;
    assign cnt_inc      = count_q + 16'd1;
    assign seq_inc      = seq_q + 16'd1;
    // A header loaded in the same cycle the previous trailer drains must already carry the bumped seq.
    assign hdr_seq      = trl_done ? seq_inc : seq_q;
    assign close_last   = s_axis_tlast;
    assign close_len    = ((len_q != 16'd0) && (cnt_inc == len_q)) || (cnt_inc == 16'hFFFF);

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign pkt_cnt       = pkt_cnt_q;

`ifdef CHAN_FRAMER_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_snap_q;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            ts_q      <= '0;
            ts_snap_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (state_q == S_IDLE && s_axis_tvalid && out_free)
                ts_snap_q <= ts_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q    <= S_IDLE;
            cur_bin_q  <= '0;
            len_q      <= '0;
            count_q    <= '0;
            reason_q   <= '0;
            seq_q      <= '0;
            pkt_cnt_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            if (trl_done) begin
                seq_q     <= seq_inc;
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (out_free) begin
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    // The triggering sample is only peeked here; it is consumed in PAYLOAD.
                    if (s_axis_tvalid && out_free) begin
                        cur_bin_q  <= s_bin;
                        len_q      <= payload_length;
                        count_q    <= '0;
                        reason_q   <= '0;
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= {SYNC_WORD, hdr_seq};
                        state_q    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (out_free) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= {{(32-BIN_WIDTH){1'b0}}, cur_bin_q};
`ifdef CHAN_FRAMER_TIMESTAMP_EN
                        state_q    <= S_TS;
`else
                        state_q    <= S_PAYLOAD;
`endif
                    end
                end
`ifdef CHAN_FRAMER_TIMESTAMP_EN
                S_TS: begin
                    if (out_free) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= ts_snap_q;
                        state_q    <= S_PAYLOAD;
                    end
                end
`endif
                S_PAYLOAD: begin
                    if (s_hs) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= s_axis_tdata;
                        count_q    <= cnt_inc;
                        if (close_last || close_len) begin
                            reason_q <= {1'b0, close_len, close_last};
                            state_q  <= S_TRAILER;
                        end
                    end else if (s_axis_tvalid && !bin_match && out_free) begin
                        reason_q <= 3'b100;
                        state_q  <= S_TRAILER;
                    end
                end
                S_TRAILER: begin
                    if (out_free) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= {count_q, 13'd0, reason_q};
                        m_tlast_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
